// File: rtl/window_sequencer.sv
// Job sequencer for the line/window convolution datapath: loads DATA_COUNT
// words into the line buffer, then runs PASSES rounds of LINE and WIND
// phases under downstream back-pressure and pulses done for one cycle.
module window_sequencer #(
  parameter int unsigned DATA_COUNT = 32,
  parameter int unsigned LINE_COUNT = 12,
  parameter int unsigned WIND_COUNT = 2,
  parameter int unsigned PASSES     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       buf_wr_en,
  output logic [5:0] buf_wr_addr,
  input  logic       out_ready,
  output logic       line_en,
  output logic       wind_en,
  output logic [5:0] count_data,
  output logic [3:0] count_line,
  output logic [1:0] count_wind,
  output logic [2:0] state,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LINE = 3'd2,
    WIND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [5:0] DATA_LAST = 6'(DATA_COUNT - 1);
  localparam logic [3:0] LINE_LAST = 4'(LINE_COUNT - 1);
  localparam logic [1:0] WIND_LAST = 2'(WIND_COUNT - 1);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [5:0] data_d;
  logic [3:0] line_d;
  logic [1:0] wind_d;
  logic [7:0] pass_cnt;
  logic [7:0] pass_d;
  logic       accept;

  // State and phase counter registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= IDLE;
      count_data <= '0;
      count_line <= '0;
      count_wind <= '0;
      pass_cnt   <= '0;
    end else begin
      cur_state  <= nxt_state;
      count_data <= data_d;
      count_line <= line_d;
      count_wind <= wind_d;
      pass_cnt   <= pass_d;
    end
  end

  // Next-state and counter advance; each phase clears its counter on its last step.
  always_comb begin
    nxt_state = cur_state;
    data_d    = count_data;
    line_d    = count_line;
    wind_d    = count_wind;
    pass_d    = pass_cnt;
    accept    = in_valid && (cur_state == LOAD);
    case (cur_state)
      IDLE: begin
        if (start) nxt_state = LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (count_data == DATA_LAST) begin
            data_d    = '0;
            nxt_state = LINE;
          end else begin
            data_d = count_data + 6'd1;
          end
        end
      end
      LINE: begin
        if (out_ready) begin
          if (count_line == LINE_LAST) begin
            line_d    = '0;
            nxt_state = WIND;
          end else begin
            line_d = count_line + 4'd1;
          end
        end
      end
      WIND: begin
        if (out_ready) begin
          if (count_wind == WIND_LAST) begin
            wind_d = '0;
            if (pass_cnt == PASS_LAST) begin
              pass_d    = '0;
              nxt_state = DONE;
            end else begin
              pass_d    = pass_cnt + 8'd1;
              nxt_state = LINE;
            end
          end else begin
            wind_d = count_wind + 2'd1;
          end
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready    = (cur_state == LOAD);
    buf_wr_en   = accept;
    buf_wr_addr = count_data;
    line_en     = (cur_state == LINE) && out_ready;
    wind_en     = (cur_state == WIND) && out_ready;
    state       = cur_state;
    busy        = (cur_state != IDLE);
    done        = (cur_state == DONE);
  end

endmodule

// File: tb/tb_window_sequencer.sv
// Bench for window_sequencer: reset/handshake vector table, directed jobs
// (plain, input gaps, back-pressure, spurious start, mid-job reset) and a
// randomized run against a job-progress reference model.
module tb_window_sequencer;

  localparam int D   = 32;
  localparam int L   = 12;
  localparam int W   = 2;
  localparam int P   = 4;
  localparam int JOB = D + P * (L + W);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, buf_wr_en, line_en, wind_en, busy, done;
  logic [5:0] buf_wr_addr, count_data;
  logic [3:0] count_line;
  logic [1:0] count_wind;
  logic [2:0] state;

  logic       in_ready1, buf_wr_en1, line_en1, wind_en1, busy1, done1;
  logic [5:0] buf_wr_addr1, count_data1;
  logic [3:0] count_line1;
  logic [1:0] count_wind1;
  logic [2:0] state1;

  int n_checks = 0;
  int n_fail   = 0;
  int d1_at;

  always #5 clk = ~clk;

  window_sequencer #(.DATA_COUNT(D), .LINE_COUNT(L), .WIND_COUNT(W), .PASSES(P)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .out_ready(out_ready),
    .line_en(line_en), .wind_en(wind_en), .count_data(count_data),
    .count_line(count_line), .count_wind(count_wind), .state(state),
    .busy(busy), .done(done)
  );

  window_sequencer #(.DATA_COUNT(D), .LINE_COUNT(L), .WIND_COUNT(W), .PASSES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .buf_wr_en(buf_wr_en1), .buf_wr_addr(buf_wr_addr1), .out_ready(out_ready),
    .line_en(line_en1), .wind_en(wind_en1), .count_data(count_data1),
    .count_line(count_line1), .count_wind(count_wind1), .state(state1),
    .busy(busy1), .done(done1)
  );

  // Reference model: a job is a linear sequence of JOB steps; phase and
  // counters are derived arithmetically from how many steps have completed.
  int m_phase = 0;  // 0 idle, 1 running, 2 done cycle
  int m_prog  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_prog  <= 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_prog  <= 0;
      end
    end else if (m_phase == 2) begin
      m_phase <= 0;
    end else if ((m_prog < D) ? in_valid : out_ready) begin
      if (m_prog + 1 == JOB) begin
        m_phase <= 2;
        m_prog  <= 0;
      end else begin
        m_prog <= m_prog + 1;
      end
    end
  end

  function automatic int m_rem();
    return (m_prog - D) % (L + W);
  endfunction

  function automatic int exp_state();
    if (m_phase == 0) return 0;
    if (m_phase == 2) return 4;
    if (m_prog < D) return 1;
    return (m_rem() < L) ? 2 : 3;
  endfunction

  function automatic int exp_cd();
    return (m_phase == 1 && m_prog < D) ? m_prog : 0;
  endfunction

  function automatic int exp_cl();
    return (exp_state() == 2) ? m_rem() : 0;
  endfunction

  function automatic int exp_cw();
    return (exp_state() == 3) ? m_rem() - L : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    int es;
    es = exp_state();
    chk("state", int'(state), es);
    chk("count_data", int'(count_data), exp_cd());
    chk("count_line", int'(count_line), exp_cl());
    chk("count_wind", int'(count_wind), exp_cw());
    chk("in_ready", int'(in_ready), int'(es == 1));
    chk("buf_wr_en", int'(buf_wr_en), int'(es == 1 && in_valid));
    chk("buf_wr_addr", int'(buf_wr_addr), exp_cd());
    chk("line_en", int'(line_en), int'(es == 2 && out_ready));
    chk("wind_en", int'(wind_en), int'(es == 3 && out_ready));
    chk("busy", int'(busy), int'(es != 0));
    chk("done", int'(done), int'(es == 4));
  endtask

  // Runs one job from IDLE; mode 0 plain, 1 input gaps, 2 back-pressure, 3 spurious start.
  task automatic run_job(input int mode, output int done_at, output int writes,
                         output int lines, output int winds, output int first_line);
    int  stall_left;
    bit  did1, did2;
    stall_left = 0; did1 = 0; did2 = 0;
    done_at = -1; writes = 0; lines = 0; winds = 0; first_line = -1; d1_at = -1;
    reset = 0; start = 1; in_valid = 1; out_ready = 1;
    tick();
    for (int idx = 0; idx < 400 && done_at < 0; idx++) begin
      start = 0; in_valid = 1; out_ready = 1;
      if (mode == 1) in_valid = (idx % 3 != 2);
      if (mode == 2) begin
        if (stall_left == 0 && !did1 && state == 3'd2 && count_line == 4'd7) begin
          stall_left = 5; did1 = 1;
        end else if (stall_left == 0 && !did2 && state == 3'd3 && count_wind == 2'd1) begin
          stall_left = 5; did2 = 1;
        end
        if (stall_left > 0) begin
          out_ready = 0;
          stall_left--;
        end
      end
      if (mode == 3) start = (state == 3'd1 && count_data == 6'd10) || state == 3'd3 || state == 3'd4;
      #2;
      check_all();
      if (mode == 2 && !out_ready) begin
        chk("stall_no_enable", int'(line_en | wind_en), 0);
        chk("stall_hold", (state == 3'd2) ? int'(count_line) : int'(count_wind),
            (state == 3'd2) ? 7 : 1);
      end
      if (buf_wr_en) begin
        chk("wr_addr_seq", int'(buf_wr_addr), writes);
        writes++;
      end
      if (line_en) lines++;
      if (wind_en) winds++;
      if (state == 3'd2 && first_line < 0) first_line = writes;
      if (done1 && d1_at < 0) d1_at = idx;
      if (done) done_at = idx;
      tick();
    end
    start = 0;
    chk("job_done_seen", int'(done_at >= 0), 1);
    #2;
    chk("idle_after_done", int'(state), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  typedef struct {
    bit rst, st, iv, ordy;
    int e_state, e_cd, e_wr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int done_at, writes, lines, winds, first_line;
    bit found;

    tbl[0] = '{1, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 1, 1, 1};
    tbl[5] = '{0, 0, 0, 1, 1, 1, 0};
    tbl[6] = '{0, 0, 1, 1, 1, 2, 1};
    tbl[7] = '{1, 0, 1, 1, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      tick();
      #2;
      chk("vec_state", int'(state), tbl[i].e_state);
      chk("vec_count_data", int'(count_data), tbl[i].e_cd);
      chk("vec_wr_en", int'(buf_wr_en), tbl[i].e_wr);
      chk("vec_line_wind_en", int'(line_en | wind_en), 0);
      check_all();
    end

    run_job(0, done_at, writes, lines, winds, first_line);
    chk("plain_done_at", done_at, JOB);
    chk("plain_writes", writes, D);
    chk("plain_lines", lines, P * L);
    chk("plain_winds", winds, P * W);
    chk("passes1_done_at", d1_at, D + L + W);

    run_job(1, done_at, writes, lines, winds, first_line);
    chk("gaps_writes", writes, D);
    chk("gaps_line_after_load", first_line, D);
    chk("gaps_done_at", done_at, JOB + 15);

    run_job(2, done_at, writes, lines, winds, first_line);
    chk("bp_lines", lines, P * L);
    chk("bp_winds", winds, P * W);
    chk("bp_done_at", done_at, JOB + 10);

    run_job(3, done_at, writes, lines, winds, first_line);
    chk("spurious_done_at", done_at, JOB);
    chk("spurious_writes", writes, D);
    tick();
    #2;
    chk("spurious_stay_idle", int'(state), 0);

    reset = 0; start = 1; in_valid = 1; out_ready = 1;
    tick();
    start = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_phase == 1 && m_prog == D + 2 * (L + W) + 5) found = 1;
      else begin
        #2;
        check_all();
        tick();
      end
    end
    chk("midreset_reached", int'(found), 1);
    chk("midreset_pre_state", int'(state), 2);
    chk("midreset_pre_line", int'(count_line), 5);
    reset = 1;
    tick();
    reset = 0;
    #2;
    chk("midreset_state", int'(state), 0);
    chk("midreset_counters", int'({count_data, count_line, count_wind}), 0);
    chk("midreset_flags", int'({in_ready, line_en, wind_en, busy, done}), 0);
    run_job(0, done_at, writes, lines, winds, first_line);
    chk("rerun_writes", writes, D);
    chk("rerun_done_at", done_at, JOB);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      #2;
      check_all();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_sequencer.md
# window_sequencer

Top-level sequencer for the line/window convolution datapath. Owns the phase counters that the window FSM and line buffer consume. It takes a `start` pulse, then loads `DATA_COUNT` words into the line buffer with a valid/ready handshake. It then alternates line-processing and window-processing phases for `PASSES` passes, back-pressured by the downstream consumer, and signals completion with a one-cycle `done` pulse.

## Interface
- `DATA_COUNT`, 32: words accepted in the LOAD phase (1..63).
- `LINE_COUNT`, 12: line steps per LINE phase (1..15).
- `WIND_COUNT`, 2: window steps per WIND phase (1..3).
- `PASSES`, 4: LINE+WIND passes per job (1..255).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `start` in 1: job request; honoured only in IDLE.
- `in_valid` in 1: input word valid (LOAD phase).
- `in_ready` out 1: `state==LOAD`, combinational from state.
- `buf_wr_en` out 1: `in_valid & in_ready`, combinational.
- `buf_wr_addr` out 6: equals `count_data`.
- `out_ready` in 1: downstream accepts a step (LINE/WIND phases).
- `line_en` out 1: `state==LINE & out_ready`.
- `wind_en` out 1: `state==WIND & out_ready`.
- `count_data` out 6, `count_line` out 4, `count_wind` out 2: registered phase counters.
- `state` out 3: IDLE=0, LOAD=1, LINE=2, WIND=3, DONE=4.
- `busy` out 1: `state!=IDLE`.
- `done` out 1: `state==DONE`.

## Operation
- Reset, synchronous: `state`=IDLE, all counters 0, internal `pass_cnt` (8 bit)=0. Outputs then follow: `in_ready`, `line_en`, `wind_en`, `buf_wr_en`, `busy` and `done` are all 0. Reset wins over every other event in the same cycle, including mid-phase.
- IDLE: `start`=1 → LOAD. `in_valid` and `out_ready` are ignored.
- LOAD: an accept is `in_valid & in_ready`.
  - Each accept increments `count_data`.
  - An accept while `count_data==DATA_COUNT-1` clears `count_data` to 0 and moves to LINE.
  - No accept: hold.
- LINE: a step is `out_ready`=1.
  - Each step increments `count_line`.
  - A step while `count_line==LINE_COUNT-1` clears it and moves to WIND.
  - `out_ready`=0: all state holds.
- WIND: a step is `out_ready`=1.
  - Each step increments `count_wind`.
  - A step while `count_wind==WIND_COUNT-1` clears it, then:
    - if `pass_cnt==PASSES-1`: `pass_cnt`←0 and state → DONE;
    - otherwise: `pass_cnt`++ and state → LINE.
- DONE: one cycle, unconditionally → IDLE. `start` asserted in DONE is ignored and must be re-presented in IDLE.
- Other rules:
  - `start` outside IDLE has no effect.
  - Counters never exceed their parameter minus 1, so no wrap logic beyond the clear-on-last rule.
  - `in_valid` outside LOAD writes nothing.

## Timing
- `start` sampled high at edge k: `state`=LOAD after edge k; first accept is possible in cycle k+1.
- Minimum job length from `start` edge to `done` high, with `in_valid` and `out_ready` held at 1: DATA_COUNT + PASSES·(LINE_COUNT+WIND_COUNT) cycles. `done` is high for the next cycle. Defaults give 32+4·14=88 cycles, then DONE.
- `buf_wr_addr` and `buf_wr_en` are valid in the same cycle as the accept; the buffer writes on that edge.
- `line_en`/`wind_en` pair with `count_line`/`count_wind` of the same cycle. The value consumed on step n is n-1, starting from 0.
- Back-pressure has zero-cycle response: deasserting `out_ready` freezes the counters at the next edge with no lost or duplicated step.
- The transition out of each phase has no bubble: the last step of LINE is followed by the WIND step 0 opportunity in the next cycle.

## Test plan
- Reset/idle: assert `reset` for 2 cycles, pulse `in_valid` and `out_ready` → `state`=0, counters 0, `in_ready`/`line_en`/`wind_en`/`busy`/`done`=0.
- Full job, no stalls (defaults): `start` for 1 cycle, `in_valid` and `out_ready` held at 1.
  - Expect 32 `buf_wr_en` pulses with addresses 0..31.
  - Then 4×(12 `line_en` + 2 `wind_en`).
  - `done` is high exactly once, 88 cycles after the `start` edge; then IDLE.
- Input gaps: drop `in_valid` every third cycle during LOAD → exactly 32 writes with contiguous addresses 0..31; LINE is entered only after address 31 is accepted.
- Back-pressure: drop `out_ready` for 5 cycles at `count_line`=7 and again at `count_wind`=1 → counters hold, no enables during the stall, and step totals are unchanged.
- Reset mid-operation: assert `reset` during LINE with `count_line`=5, `pass_cnt`=2 → IDLE with all zero next cycle. A fresh `start` reruns the full 32-word load.
- Spurious start: pulse `start` during LOAD, WIND and DONE → no restart and no counter disturbance; `PASSES`=1 configuration gives a job length of 32+14 cycles.
